// File: rtl/rv_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package rv_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StResp   = 2'd2
   } state_e;

   typedef enum logic {
      OwnFetch = 1'b0,
      OwnData  = 1'b1
   } owner_e;

   // A data write of DONE_DATA to DONE_ADDR raises the sticky done flag.
   localparam logic [31:0] DONE_ADDR = 32'h0000_FFFF;
   localparam logic [31:0] DONE_DATA = 32'h0000_DEAD;

   // Wide enough to hold the largest legal MEM_LAT.
   localparam int unsigned CNT_W = 3;

   function automatic owner_e other_owner(input owner_e o);
      return (o == OwnFetch) ? OwnData : OwnFetch;
   endfunction

endpackage

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin pick between fetch and data requests.
module rv_rr_arb2
   import rv_pkg::*;
(
   input  logic   i_f_req,
   input  logic   i_d_req,
   input  owner_e i_last,
   output logic   o_valid,
   output owner_e o_grant
);

   always_comb begin
      o_valid = i_f_req | i_d_req;
      o_grant = OwnFetch;
      if (i_f_req && i_d_req) begin
         o_grant = other_owner(i_last);
      end else if (i_d_req) begin
         o_grant = OwnData;
      end
   end

endmodule

// File: rtl/rv_mem_arb.sv
// Arbiter sharing one single-port memory between a fetch and a data requester.
module rv_mem_arb
   import rv_pkg::*;
#(
   parameter int unsigned DPWIDTH = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               f_req,
   input  logic [DPWIDTH-1:0] f_addr,
   output logic [DPWIDTH-1:0] f_rdata,
   output logic               f_ack,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [DPWIDTH-1:0] d_addr,
   input  logic [DPWIDTH-1:0] d_wdata,
   output logic [DPWIDTH-1:0] d_rdata,
   output logic               d_ack,
   output logic               mem_en,
   output logic               mem_we,
   output logic [DPWIDTH-1:0] mem_addr,
   output logic [DPWIDTH-1:0] mem_wdata,
   input  logic [DPWIDTH-1:0] mem_rdata,
   output logic               done
);

   state_e             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   owner_e             r_last, w_last_nxt;
   owner_e             r_owner, w_owner_nxt;
   logic               r_mem_en, w_mem_en_nxt;
   logic               r_mem_we, w_mem_we_nxt;
   logic [DPWIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [DPWIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
   logic               r_f_ack, w_f_ack_nxt;
   logic               r_d_ack, w_d_ack_nxt;
   logic [DPWIDTH-1:0] r_f_rdata, w_f_rdata_nxt;
   logic [DPWIDTH-1:0] r_d_rdata, w_d_rdata_nxt;
   logic               r_done, w_done_nxt;

   logic               w_gnt_valid;
   owner_e             w_gnt;

   rv_rr_arb2 u_arb (
      .i_f_req (f_req),
      .i_d_req (d_req),
      .i_last  (r_last),
      .o_valid (w_gnt_valid),
      .o_grant (w_gnt)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_last_nxt      = r_last;
      w_owner_nxt     = r_owner;
      w_mem_en_nxt    = r_mem_en;
      w_mem_we_nxt    = 1'b0;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_f_ack_nxt     = 1'b0;
      w_d_ack_nxt     = 1'b0;
      w_f_rdata_nxt   = r_f_rdata;
      w_d_rdata_nxt   = r_d_rdata;
      w_done_nxt      = r_done;

      unique case (r_state)
         StIdle: begin
            w_mem_en_nxt = 1'b0;
            if (w_gnt_valid) begin
               w_state_nxt  = StAccess;
               w_cnt_nxt    = CNT_W'(MEM_LAT);
               w_owner_nxt  = w_gnt;
               w_last_nxt   = w_gnt;
               w_mem_en_nxt = 1'b1;
               if (w_gnt == OwnData) begin
                  w_mem_addr_nxt  = d_addr;
                  w_mem_we_nxt    = d_we;
                  w_mem_wdata_nxt = d_wdata;
                  if (d_we && (d_addr == DPWIDTH'(DONE_ADDR)) &&
                      (d_wdata == DPWIDTH'(DONE_DATA))) begin
                     w_done_nxt = 1'b1;
                  end
               end else begin
                  w_mem_addr_nxt = f_addr;
               end
            end
         end
         StAccess: begin
            // mem_en spans MEM_LAT cycles; the final count-0 cycle waits for read data.
            if (r_cnt == '0) begin
               w_state_nxt  = StResp;
               w_mem_en_nxt = 1'b0;
               if (r_owner == OwnData) begin
                  w_d_rdata_nxt = mem_rdata;
                  w_d_ack_nxt   = 1'b1;
               end else begin
                  w_f_rdata_nxt = mem_rdata;
                  w_f_ack_nxt   = 1'b1;
               end
            end else begin
               w_cnt_nxt    = r_cnt - 1'b1;
               w_mem_en_nxt = (r_cnt > CNT_W'(1));
            end
         end
         StResp: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt  = StIdle;
            w_mem_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_last      <= OwnFetch;
         r_owner     <= OwnFetch;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_f_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_f_rdata   <= '0;
         r_d_rdata   <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_last      <= w_last_nxt;
         r_owner     <= w_owner_nxt;
         r_mem_en    <= w_mem_en_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_f_ack     <= w_f_ack_nxt;
         r_d_ack     <= w_d_ack_nxt;
         r_f_rdata   <= w_f_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign f_ack     = r_f_ack;
   assign d_ack     = r_d_ack;
   assign f_rdata   = r_f_rdata;
   assign d_rdata   = r_d_rdata;
   assign done      = r_done;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: one instance with MEM_LAT=1 and one with MEM_LAT=3.
module tb_rv_mem_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        f_req [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [31:0] f_addr [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];
   logic [31:0] f_rdata [2];
   logic [31:0] d_rdata [2];
   logic        f_ack [2];
   logic        d_ack [2];
   logic        mem_en [2];
   logic        mem_we [2];
   logic [31:0] mem_addr [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        done [2];

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] ref_mem [2][1024];
   int          last_d [2];
   logic [31:0] exp_f_rd [2];
   logic [31:0] exp_d_rd [2];
   logic        exp_done [2];
   logic [3:0]  tie_seq;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'h0050_0093;
      return 32'(i) * 32'h0101_0103 + 32'h7;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : 3;

      rv_mem_arb #(
         .DPWIDTH (32),
         .MEM_LAT (LAT)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .f_req     (f_req[g]),
         .f_addr    (f_addr[g]),
         .f_rdata   (f_rdata[g]),
         .f_ack     (f_ack[g]),
         .d_req     (d_req[g]),
         .d_we      (d_we[g]),
         .d_addr    (d_addr[g]),
         .d_wdata   (d_wdata[g]),
         .d_rdata   (d_rdata[g]),
         .d_ack     (d_ack[g]),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g]),
         .done      (done[g])
      );

      // Memory: read data appears LAT cycles after en is sampled.
      logic [31:0] mem [1024];
      logic [31:0] pipe [LAT];
      initial for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
      always @(posedge clk) begin
         if (mem_en[g]) begin
            pipe[0] <= mem[mem_addr[g][9:0]];
            if (mem_we[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
         end
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         last_d[k]   = 0;
         exp_f_rd[k] = '0;
         exp_d_rd[k] = '0;
         exp_done[k] = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input int k);
      chk("rst_mem_en", mem_en[k], 0);
      chk("rst_mem_we", mem_we[k], 0);
      chk("rst_mem_addr", mem_addr[k], 0);
      chk("rst_mem_wdata", mem_wdata[k], 0);
      chk("rst_f_ack", f_ack[k], 0);
      chk("rst_d_ack", d_ack[k], 0);
      chk("rst_f_rdata", f_rdata[k], 0);
      chk("rst_d_rdata", d_rdata[k], 0);
      chk("rst_done", done[k], 0);
   endtask

   // Entered just after a rising edge with the DUT idle; the next edge is the grant.
   task automatic serve(input int k);
      int          lat;
      int          w;
      logic [31:0] a;
      logic [31:0] exp_rd;
      logic        wr;
      lat = (k == 0) ? 1 : 3;
      if (f_req[k] && d_req[k]) w = (last_d[k] != 0) ? 0 : 1;
      else                      w = d_req[k] ? 1 : 0;
      last_d[k] = w;
      a      = (w != 0) ? d_addr[k] : f_addr[k];
      exp_rd = ref_mem[k][a[9:0]];
      wr     = (w != 0) && d_we[k];
      if (wr) begin
         ref_mem[k][a[9:0]] = d_wdata[k];
         if (a == 32'h0000_FFFF && d_wdata[k] == 32'h0000_DEAD) exp_done[k] = 1'b1;
      end
      if (w != 0) exp_d_rd[k] = exp_rd;
      else        exp_f_rd[k] = exp_rd;
      @(posedge clk);
      for (int c = 0; c <= lat + 1; c++) begin
         @(negedge clk);
         chk("mem_en", mem_en[k], 32'(c < lat));
         chk("mem_we", mem_we[k], 32'(wr && c == 0));
         chk("f_ack", f_ack[k], 32'(w == 0 && c == lat + 1));
         chk("d_ack", d_ack[k], 32'(w != 0 && c == lat + 1));
         if (c < lat) chk("mem_addr", mem_addr[k], a);
         if (c == 0) begin
            chk("done", done[k], 32'(exp_done[k]));
            if (wr) chk("mem_wdata", mem_wdata[k], d_wdata[k]);
         end
         if (c == lat + 1) begin
            chk("f_rdata", f_rdata[k], exp_f_rd[k]);
            chk("d_rdata", d_rdata[k], exp_d_rd[k]);
            tie_seq = {tie_seq[2:0], d_ack[k]};
         end
         if (c < lat + 1) @(posedge clk);
      end
      if (w != 0) d_req[k] = 1'b0;
      else        f_req[k] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int k);
      while (f_req[k] || d_req[k]) serve(k);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      tie_seq = '0;
      for (int k = 0; k < 2; k++) begin
         f_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
         f_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
         for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
      end
      reset_model();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero(0);
      chk_all_zero(1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Ties right after reset: data first, then alternate
      for (int r = 0; r < 2; r++) begin
         f_req[0] = 1; f_addr[0] = 32'h100 + 32'(r);
         d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h200 + 32'(r);
         drain(0);
      end
      chk("tie_order", {28'h0, tie_seq}, 32'hA);

      // Single fetch
      f_req[0] = 1; f_addr[0] = 32'h10;
      serve(0);
      chk("fetch_word", f_rdata[0], 32'h0050_0093);

      // Data write then readback
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h40; d_wdata[0] = 32'h1234;
      serve(0);
      d_we[0] = 0;
      f_req[0] = 1; f_addr[0] = 32'h40;
      serve(0);
      chk("readback", f_rdata[0], 32'h1234);

      // Completion write, then done must persist
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'hFFFF; d_wdata[0] = 32'hDEAD;
      serve(0);
      d_we[0] = 0;
      chk("done_set", done[0], 1);
      f_req[0] = 1; f_addr[0] = 32'h8;
      d_req[0] = 1; d_addr[0] = 32'hC;
      drain(0);
      chk("done_held", done[0], 1);

      // MEM_LAT=3 fetch
      f_req[1] = 1; f_addr[1] = 32'h10;
      serve(1);
      chk("fetch_lat3", f_rdata[1], 32'h0050_0093);

      // Randomized mix on both instances
      for (int i = 0; i < 25; i++) begin
         for (int k = 0; k < 2; k++) begin
            f_req[k]   = 1'($urandom_range(0, 1));
            d_req[k]   = f_req[k] ? 1'($urandom_range(0, 1)) : 1'b1;
            f_addr[k]  = $urandom;
            d_addr[k]  = $urandom;
            d_we[k]    = 1'($urandom_range(0, 1));
            d_wdata[k] = $urandom;
            drain(k);
         end
      end
      d_we[0] = 0;
      d_we[1] = 0;

      // Reset in the second access cycle of the MEM_LAT=3 instance
      f_req[1] = 1; f_addr[1] = 32'h20;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_all_zero(1);
      chk_all_zero(0);
      reset_model();
      f_req[1] = 0;
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold_ack", f_ack[1], 0);
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_we", mem_we[1], 0);
         chk("post_rst_en", mem_en[1], 0);
         chk("post_rst_fack", f_ack[1], 0);
      end
      @(posedge clk);
      #1;
      f_req[1] = 1; f_addr[1] = 32'h10;
      serve(1);
      chk("fetch_after_rst", f_rdata[1], 32'h0050_0093);

      // last_grant back to fetch after reset: tie goes to data
      tie_seq = '0;
      f_req[0] = 1; f_addr[0] = 32'h30;
      d_req[0] = 1; d_addr[0] = 32'h34;
      drain(0);
      chk("tie_after_rst", {30'h0, tie_seq[1:0]}, 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
